// File: rtl/nibble_link_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_link_pkg
//  Description : Definitions shared by both directions of the nibble-serial
//                host link: nibble geometry and the link FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_link_pkg;

    localparam int NIB_W   = 4;
    localparam int NIBBLES = 8;

    // Encoding is shared with the instruction receiver's link FSM.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_PRESENT = 2'd2,
        ST_RELEASE = 2'd3
    } link_state_t;

endpackage : nibble_link_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : 1-bit two-flop synchronizer, asynchronous reset to 0.
//  Ports       : clk   - destination clock
//                rst_n - asynchronous active-low reset
//                d     - asynchronous input
//                q     - synchronized output (2 clk edges of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import nibble_link_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/nibble_result_tx.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_result_tx
//  Description : Captures a PCPI write-back result and sends it to the host
//                as NIBBLES nibbles, LSB first, each with a four-phase
//                valid/ack handshake.
//  Ports       : clk, rst_n          - clock, async active-low reset
//                pcpi_ready/wr/rd    - coprocessor result interface
//                tx_ack              - host acknowledge (asynchronous)
//                tx_valid/nibble/last- nibble presented to the host
//                busy                - buffer occupied (FSM not IDLE)
//                done                - pulse when the last handshake ends
//                overrun             - pulse when a result is dropped
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_result_tx
    import nibble_link_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NIB_W  = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pcpi_ready,
    input  logic              pcpi_wr,
    input  logic [DATA_W-1:0] pcpi_rd,
    input  logic              tx_ack,
    output logic              tx_valid,
    output logic [NIB_W-1:0]  tx_nibble,
    output logic              tx_last,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int c_NIBBLES = DATA_W / NIB_W;
    localparam int c_CNT_W   = (c_NIBBLES > 1) ? $clog2(c_NIBBLES) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_NIBBLES - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    link_state_t         r_state,   w_state_nxt;
    logic [DATA_W-1:0]   r_shift,   w_shift_nxt;
    logic [c_CNT_W-1:0]  r_cnt,     w_cnt_nxt;
    logic                w_ack_s;
    logic                w_capture;
    logic                w_valid_nxt;
    logic [NIB_W-1:0]    w_nibble_nxt;
    logic                w_last_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_overrun_nxt;

    sync_2ff u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tx_ack),
        .q     (w_ack_s)
    );

    assign w_capture = pcpi_ready && pcpi_wr;

    // Outputs are derived from the next-state values so that they come
    // straight out of flops and change on the same edge as the state.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_capture) begin
                    w_shift_nxt = pcpi_rd;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_ARM;
                end
            end
            // Wait out any ack left high by the host before presenting.
            ST_ARM: begin
                if (!w_ack_s) w_state_nxt = ST_PRESENT;
            end
            ST_PRESENT: begin
                if (w_ack_s) w_state_nxt = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!w_ack_s) begin
                    if (r_cnt == c_LAST) begin
                        w_state_nxt = ST_IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_shift_nxt = r_shift >> NIB_W;
                        w_cnt_nxt   = r_cnt + c_ONE;
                        w_state_nxt = ST_PRESENT;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_valid_nxt   = (w_state_nxt == ST_PRESENT);
        w_nibble_nxt  = w_valid_nxt ? w_shift_nxt[NIB_W-1:0] : '0;
        w_last_nxt    = w_valid_nxt && (w_cnt_nxt == c_LAST);
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        w_overrun_nxt = w_capture && (r_state != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_cnt     <= '0;
            tx_valid  <= 1'b0;
            tx_nibble <= '0;
            tx_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_cnt     <= w_cnt_nxt;
            tx_valid  <= w_valid_nxt;
            tx_nibble <= w_nibble_nxt;
            tx_last   <= w_last_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
            overrun   <= w_overrun_nxt;
        end
    end

endmodule : nibble_result_tx
`default_nettype wire
